// File: rtl/switch_reader_4bits.sv
// Four-pin switch reader: two-stage synchronizer, prescaled per-bit debouncer,
// and a valid/ack event register reporting which bits changed since the last ack.
module switch_reader_4bits #(
  parameter int N  = 22,
  parameter int DB = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       ack,
  output logic [3:0] data,
  output logic [3:0] changed,
  output logic       valid,
  output logic       overrun
);

  // Handshake: valid stays high while an event is pending; the consumer
  // drives ack high for at least one cycle while valid=1 to retire it.
  // ack while idle has no effect.

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [3:0] DB_LAST = 4'(DB - 1);

  state_t       state, state_nx;
  logic [3:0]   s1, s2;
  logic [N-1:0] pre;
  logic         tick;
  logic [3:0]   cnt [4];
  logic [3:0]   commit;
  logic         ev;
  logic [3:0]   changed_nx;
  logic         overrun_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      pre <= '0;
    end else begin
      s1  <= sw;
      s2  <= s1;
      pre <= pre + 1'b1;
    end
  end

  assign tick = &pre;

  always_comb begin
    commit = '0;
    for (int i = 0; i < 4; i++) begin
      commit[i] = tick && (s2[i] != data[i]) && (cnt[i] == DB_LAST);
    end
  end

  assign ev = |commit;

  // A matching tick restarts the run, so only DB back-to-back mismatches flip data.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == data[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          data[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    changed_nx = changed;
    overrun_nx = overrun;
    case (state)
      IDLE: begin
        if (ev) begin
          state_nx   = PENDING;
          changed_nx = commit;
        end
      end
      PENDING: begin
        if (ack) begin
          overrun_nx = 1'b0;
          if (ev) begin
            changed_nx = commit;
          end else begin
            state_nx   = IDLE;
            changed_nx = '0;
          end
        end else if (ev) begin
          changed_nx = changed | commit;
          overrun_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      changed <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      changed <= changed_nx;
      overrun <= overrun_nx;
    end
  end

  assign valid = (state == PENDING);

endmodule
